// File: rtl/ypipe_ctl.sv
// ypipe_ctl: five-stage pipeline sequencer with PC, valid chain, hazard scoreboard and interrupt drain.
// Define YPIPE_FWD_EN for EX operand forwarding; otherwise RAW hazards stall until write-through.
module ypipe_ctl #(
  parameter int XLEN   = 32,
  parameter int RW     = 5,
  parameter int ILEN_B = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] entryPoint,
  input  logic            INT,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] pc,
  output logic            if_valid,
  output logic            id_valid,
  output logic            ex_valid,
  output logic            mem_valid,
  output logic            wb_valid,
  output logic            stall,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [XLEN-1:0] epc,
  output logic            int_ack
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, VECTOR = 2'd2;
  logic [1:0] state;
  logic pending, redirect, accept, drained, ex_kill, hazard, hit_ex;
  logic [XLEN-1:0] id_pc;
  logic [RW-1:0] ex_rd, mem_rd;
  logic ex_regwrite, ex_memread, mem_regwrite;
  assign hit_ex = ex_rd != '0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign redirect = state == RUN && ex_redirect && ex_valid;
  assign stall = hazard && !redirect;
  assign accept = state == RUN && (pending || INT) && !stall;
  assign int_ack = state == VECTOR;
  assign drained = !(ex_valid || mem_valid || wb_valid);
  assign ex_kill = accept || redirect || stall || !id_valid;
`ifdef YPIPE_FWD_EN
  logic [RW-1:0] ex_rs1, ex_rs2, wb_rd;
  logic wb_regwrite, m_ok, w_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      wb_rd <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      ex_rs1 <= id_rs1;
      ex_rs2 <= id_rs2;
      wb_rd <= mem_rd;
      wb_regwrite <= mem_regwrite;
    end
  end
  assign m_ok = mem_valid && mem_regwrite && mem_rd != '0;
  assign w_ok = wb_valid && wb_regwrite && wb_rd != '0;
  assign fwd_a = (m_ok && mem_rd == ex_rs1) ? 2'b01 : (w_ok && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
  assign fwd_b = (m_ok && mem_rd == ex_rs2) ? 2'b01 : (w_ok && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
  assign hazard = id_valid && ex_valid && ex_memread && hit_ex;
`else
  logic hit_mem;
  assign hit_mem = mem_rd != '0 && ((id_use_rs1 && id_rs1 == mem_rd) || (id_use_rs2 && id_rs2 == mem_rd));
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
  // a load always targets rd, so it counts as a writer even if regwrite is dropped
  assign hazard = id_valid && ((ex_valid && (ex_regwrite || ex_memread) && hit_ex) ||
                               (mem_valid && mem_regwrite && hit_mem));
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= entryPoint;
      {if_valid, id_valid, ex_valid, mem_valid, wb_valid} <= '0;
      state <= RUN;
      pending <= 1'b0;
      epc <= '0;
      id_pc <= '0;
      ex_rd <= '0;
      ex_regwrite <= 1'b0;
      ex_memread <= 1'b0;
      mem_rd <= '0;
      mem_regwrite <= 1'b0;
    end else begin
      pc <= int_ack ? entryPoint : redirect ? ex_target : (stall || !if_valid) ? pc : pc + XLEN'(ILEN_B);
      if_valid <= int_ack || (state == RUN && !accept);
      id_valid <= (accept || redirect) ? 1'b0 : stall ? id_valid : if_valid;
      if (!stall) id_pc <= pc;
      ex_valid <= !ex_kill;
      ex_rd <= id_rd;
      ex_regwrite <= !ex_kill && id_regwrite;
      ex_memread <= !ex_kill && id_memread;
      mem_valid <= ex_valid;
      mem_rd <= ex_rd;
      mem_regwrite <= ex_regwrite;
      wb_valid <= mem_valid;
      state <= accept ? DRAIN : state == DRAIN ? (drained ? VECTOR : DRAIN) : RUN;
      pending <= int_ack ? 1'b0 : state == RUN ? (pending || INT) : pending;
      if (accept) epc <= redirect ? ex_target : id_valid ? id_pc : pc;
    end
  end
endmodule
